regfile_wb_queue: RTL and testbench



---
 rtl/regfile_wb_queue_pkg.sv | 40 ++++
 rtl/regfile_wb_queue_wb_fifo.sv | 100 ++++++++++
 rtl/regfile_wb_queue.sv | 162 ++++++++++++++++
 tb/tb_regfile_wb_queue.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue_pkg
//
// Purpose:
//   Shared definitions for the writeback queue in front of the 32x32 MIPS
//   register file. It holds the register-file geometry, the $zero register
//   number, the queued entry layout and a one-hot decode helper that the
//   pending scoreboard uses.
//
// Contents:
//   REG_ADDR_W  register address width (5)
//   WORD_W      register word width (32)
//   NUM_REGS    number of architectural registers (32)
//   REG_ZERO    register number of $zero; writes to it are dropped
//   wb_entry_t  packed {addr, data} record stored in the FIFO
//   reg_onehot  one-hot decode of a register number
// -----------------------------------------------------------------------------
package regfile_wb_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_queue_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//
// Purpose:
//   Generic synchronous in-order FIFO. Besides the usual head/full/empty view
//   it exposes every storage slot, a per-slot valid bit and the read pointer,
//   so the owner can search the queued contents (hazard scoreboard, bypass).
//
// Parameters:
//   DEPTH  number of entries, power of two, at least 2
//   W      entry width in bits
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset; empties the FIFO
//   i_push    write i_din at the tail (ignored while full)
//   i_din     entry to write
//   i_pop     drop the head entry (ignored while empty)
//   o_full    count == DEPTH
//   o_empty   count == 0
//   o_head    entry at the read pointer
//   o_vld     per-slot valid bits, indexed by storage slot
//   o_mem     raw storage slots
//   o_rd_ptr  slot index of the head (oldest) entry
// -----------------------------------------------------------------------------
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [W-1:0]               o_head,
    output logic [DEPTH-1:0]           o_vld,
    output logic [W-1:0]               o_mem [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   o_rd_ptr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Guard the requests so a misbehaving caller can never corrupt state.
    assign w_push = i_push && !w_full;
    assign w_pop  = i_pop  && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Push and pop never address the same slot: that would need
            // count==0 (pop blocked) or count==DEPTH (push blocked).
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full   = w_full;
    assign o_empty  = w_empty;
    assign o_head   = r_mem[r_rd_ptr];
    assign o_vld    = r_vld;
    assign o_mem    = r_mem;
    assign o_rd_ptr = r_rd_ptr;

endmodule

// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//
// Purpose:
//   Write-side companion to the 32x32 MIPS register file. Writeback results
//   are accepted through a valid/ready handshake, queued in order, and
//   drained onto the regfile write port (a3/wd3/we3) whenever the port is
//   not held. A pending-write scoreboard lets issue logic stall on RAW
//   hazards against results that have not reached the regfile yet.
//
// Optional feature (macro WB_BYPASS_EN):
//   Adds two forwarding lookup ports that return the youngest queued value
//   for a register, so decode can forward instead of stalling.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset; discards all queued writes
//   in_valid   a writeback result is offered
//   in_ready   queue can accept (== !full, registered state only)
//   in_addr    destination register
//   in_data    result value
//   wb_hold    regfile write port unavailable this cycle
//   a3/wd3/we3 regfile write port (a3/wd3 are 0 when we3 is 0)
//   pending    bit i set while a queued entry targets register i
//   empty      no entries queued
//   fwd_addr1/2, fwd_hit1/2, fwd_data1/2  (WB_BYPASS_EN only)
//
// Input handshake: a transfer happens at a rising edge where in_valid and
// in_ready are both 1. The producer holds in_addr/in_data stable while
// in_valid is 1 and in_ready is 0. in_ready depends only on registered
// state, never on in_valid or wb_hold. A transfer to $zero completes but
// stores nothing.
// -----------------------------------------------------------------------------
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       in_addr,
    input  logic [DW-1:0]       in_data,
    input  logic                wb_hold,
    output logic [AW-1:0]       a3,
    output logic [DW-1:0]       wd3,
    output logic                we3,
    output logic [NUM_REGS-1:0] pending,
    output logic                empty
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]       fwd_addr1,
    input  logic [AW-1:0]       fwd_addr2,
    output logic                fwd_hit1,
    output logic                fwd_hit2,
    output logic [DW-1:0]       fwd_data1,
    output logic [DW-1:0]       fwd_data2
`endif
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t            w_in_entry;
    wb_entry_t            w_head;
    logic [ENTRY_W-1:0]   w_head_raw;
    logic [ENTRY_W-1:0]   w_mem_raw [DEPTH];
    logic [DEPTH-1:0]     w_vld;
    logic [PW-1:0]        w_rd_ptr;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_drain;
    logic [NUM_REGS-1:0]  w_pending;

    // $zero writes complete the handshake but never occupy a slot.
    assign w_in_entry.addr = in_addr;
    assign w_in_entry.data = in_data;
    assign w_push          = in_valid && !w_full && (in_addr != REG_ZERO);

    // The head is written this cycle and popped at the coming edge.
    assign w_drain = !w_empty && !wb_hold;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (clock),
        .rst      (reset),
        .i_push   (w_push),
        .i_din    (w_in_entry),
        .i_pop    (w_drain),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_head   (w_head_raw),
        .o_vld    (w_vld),
        .o_mem    (w_mem_raw),
        .o_rd_ptr (w_rd_ptr)
    );

    assign w_head = wb_entry_t'(w_head_raw);

    assign in_ready = !w_full;
    assign empty    = w_empty;
    assign we3      = w_drain;
    assign a3       = w_drain ? w_head.addr : '0;
    assign wd3      = w_drain ? w_head.data : '0;

    // Scoreboard: OR of one-hot decodes of every valid slot. A popped
    // slot drops out after the pop edge; a duplicate target keeps its bit.
    always_comb begin
        wb_entry_t e;
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            e = wb_entry_t'(w_mem_raw[i]);
            if (w_vld[i]) begin
                w_pending = w_pending | reg_onehot(e.addr);
            end
        end
        w_pending[0] = 1'b0;
    end

    assign pending = w_pending;

`ifdef WB_BYPASS_EN
    // Walk slots from oldest to youngest so the last match, i.e. the
    // youngest write to the register, is the one that is forwarded.
    always_comb begin
        wb_entry_t     e;
        logic [PW-1:0] idx;
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_rd_ptr + PW'(k);
            e   = wb_entry_t'(w_mem_raw[idx]);
            if (w_vld[idx] && (fwd_addr1 != REG_ZERO) && (e.addr == fwd_addr1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = e.data;
            end
            if (w_vld[idx] && (fwd_addr2 != REG_ZERO) && (e.addr == fwd_addr2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = e.data;
            end
        end
    end
`else
    // Without forwarding the read pointer and stored data are only needed
    // through the head; fold them into a sink so the intent is explicit.
    logic w_unused_sink;
    always_comb begin
        w_unused_sink = ^w_rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_unused_sink = w_unused_sink ^ (^w_mem_raw[i]);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          wb_hold;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic          we3;
    logic [31:0]   pending;
    logic          empty;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] fwd_addr1;
    logic [AW-1:0] fwd_addr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    rf [32];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    regfile_wb_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wb_hold  (wb_hold),
        .a3       (a3),
        .wd3      (wd3),
        .we3      (we3),
        .pending  (pending),
        .empty    (empty)
`ifdef WB_BYPASS_EN
        ,
        .fwd_addr1 (fwd_addr1),
        .fwd_addr2 (fwd_addr2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
`endif
    );

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- regfile model ----------------
    always @(posedge clock) begin
        if (!reset && we3) rf[a3] <= wd3;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [AW+DW-1:0] e;
        if (!reset) begin
            check_val("pending_bit0", 32'(pending[0]), 32'd0);
            if (we3) begin
                check_val("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("wb_a3", 32'(a3), 32'(e[AW+DW-1:DW]));
                    check_val("wb_wd3", wd3, e[DW-1:0]);
                end
            end else begin
                check_val("idle_a3", 32'(a3), 32'd0);
                check_val("idle_wd3", wd3, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("push_accepted", 32'(ok), 32'd1);
        if (ok) begin
            if (a != 0) exp_q.push_back({a, d});
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (empty) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("drain_done", 32'(ok), 32'd1);
        @(posedge clock);
        #1;
        check_val("sb_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        wb_hold  = 1'b0;
`ifdef WB_BYPASS_EN
        fwd_addr1 = '0;
        fwd_addr2 = '0;
`endif
        for (int i = 0; i < 32; i++) rf[i] = '0;

        repeat (2) @(posedge clock);
        #1;
        check_val("rst_we3",      32'(we3),      32'd0);
        check_val("rst_a3",       32'(a3),       32'd0);
        check_val("rst_wd3",      wd3,           32'd0);
        check_val("rst_pending",  pending,       32'd0);
        check_val("rst_empty",    32'(empty),    32'd1);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single push, latency one cycle.
        push(5'd8, 32'hDEADBEEF);
        check_val("lat_we3",     32'(we3), 32'd1);
        check_val("lat_a3",      32'(a3),  32'd8);
        check_val("lat_wd3",     wd3,      32'hDEADBEEF);
        check_val("lat_pending", pending,  32'h0000_0100);
        @(posedge clock);
        #1;
        check_val("post_empty",   32'(empty), 32'd1);
        check_val("post_pending", pending,    32'd0);
        check_val("rf8",          rf[8],      32'hDEADBEEF);

        // $zero write dropped.
        push(5'd0, 32'h1234);
        check_val("zero_empty",    32'(empty),    32'd1);
        check_val("zero_pending",  pending,       32'd0);
        check_val("zero_in_ready", 32'(in_ready), 32'd1);
        check_val("zero_we3",      32'(we3),      32'd0);
        @(posedge clock);
        #1;
        check_val("zero_we3_late", 32'(we3), 32'd0);

        // Fill under hold, stalled fifth offer, ordered drain.
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(AW'(i), 32'h100 + 32'(i));
        check_val("full_in_ready", 32'(in_ready), 32'd0);
        check_val("full_pending",  pending,       32'h0000_001E);
        check_val("full_we3",      32'(we3),      32'd0);
        in_valid = 1'b1;
        in_addr  = 5'd9;
        in_data  = 32'h999;
        repeat (3) begin
            @(negedge clock);
            check_val("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        wb_hold = 1'b0;
        @(negedge clock);
        check_val("pop_cycle_in_ready", 32'(in_ready), 32'd0);
        check_val("pop_cycle_we3",      32'(we3),      32'd1);
        @(negedge clock);
        check_val("reopen_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back({5'd9, 32'h999});
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check_val("drain_consecutive", 32'(we3), 32'd1);
        end
        @(posedge clock);
        #1;
        check_val("drain_empty", 32'(empty), 32'd1);

        // Same register twice: later write wins, pending held until last pop.
        wb_hold = 1'b1;
        push(5'd5, 32'hA);
        push(5'd5, 32'hB);
        check_val("dup_pending", pending, 32'h0000_0020);
        wb_hold = 1'b0;
        @(posedge clock);
        #1;
        check_val("dup_pending_after_first", pending, 32'h0000_0020);
        @(posedge clock);
        #1;
        check_val("dup_pending_cleared", pending,    32'd0);
        check_val("dup_empty",           32'(empty), 32'd1);
        check_val("rf5_final",           rf[5],      32'hB);

        // Asynchronous reset with entries queued.
        wb_hold = 1'b1;
        push(5'd10, 32'hAAAA_0010);
        push(5'd11, 32'hAAAA_0011);
        push(5'd12, 32'hAAAA_0012);
        check_val("pre_rst_pending", pending, 32'h0000_1C00);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_we3",      32'(we3),      32'd0);
        check_val("arst_pending",  pending,       32'd0);
        check_val("arst_empty",    32'(empty),    32'd1);
        check_val("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        wb_hold = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check_val("arst_still_empty", 32'(empty), 32'd1);
        check_val("arst_rf10",        rf[10],     32'd0);
        check_val("arst_rf12",        rf[12],     32'd0);

`ifdef WB_BYPASS_EN
        wb_hold = 1'b1;
        push(5'd7, 32'h11);
        push(5'd7, 32'h22);
        fwd_addr1 = 5'd7;
        fwd_addr2 = 5'd0;
        #1;
        check_val("fwd_hit1",  32'(fwd_hit1), 32'd1);
        check_val("fwd_data1", fwd_data1,     32'h22);
        check_val("fwd_hit2",  32'(fwd_hit2), 32'd0);
        check_val("fwd_data2", fwd_data2,     32'd0);
        fwd_addr1 = 5'd3;
        fwd_addr2 = 5'd7;
        #1;
        check_val("fwd_miss_hit1",  32'(fwd_hit1), 32'd0);
        check_val("fwd_miss_data1", fwd_data1,     32'd0);
        check_val("fwd_hit2_b",     32'(fwd_hit2), 32'd1);
        check_val("fwd_data2_b",    fwd_data2,     32'h22);
        wb_hold = 1'b0;
        wait_empty();
`endif

        // Random traffic with sporadic hold.
        for (int n = 0; n < 60; n++) begin
            wb_hold = in_ready && ($urandom_range(0, 3) == 0);
            push(AW'($urandom_range(0, 31)), $urandom);
        end
        wb_hold = 1'b0;
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
